seleccionar_cartas_n: RTL

Parametrised successor of the two-card round selector for the memory-game board. It holds a cursor over an N-card board laid out as a grid, moved left/right/up/down with wrap-around. Each round the player marks up to PICKS hidden cards as selected. The finished board goes to the match checker, along with the selected indices.

---
 rtl/cartas_pkg.sv | 26 ++
 rtl/flanco_subida.sv | 31 +++
 rtl/seleccionar_cartas_n.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cartas_pkg.sv
// -----------------------------------------------------------------------------
// cartas_pkg
// Shared definitions for the memory-game card selector.
//   - Card state codes, held in bits [1:0] of every card word.
//   - Round FSM state type.
//   - is_hidden(): tells whether a card state code can still be picked.
// -----------------------------------------------------------------------------
package cartas_pkg;

    localparam logic [1:0] ST_HIDDEN = 2'b00;
    localparam logic [1:0] ST_SEL    = 2'b01;
    localparam logic [1:0] ST_MATCH  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } sel_state_t;

    // Only face-down cards can be picked; selected, matched and the reserved
    // code are all treated as off-limits.
    function automatic logic is_hidden(input logic [1:0] st);
        return st == ST_HIDDEN;
    endfunction

endpackage

// File: rtl/flanco_subida.sv
// -----------------------------------------------------------------------------
// flanco_subida
// One-bit registered rising-edge detector. A button held high produces a
// single one-cycle pulse on the cycle it first reads high.
// Ports:
//   clk     - clock
//   rst     - asynchronous reset, active low (clears the history bit)
//   din_i   - level input (button)
//   pulse_o - din_i & ~previous din_i
// -----------------------------------------------------------------------------
module flanco_subida (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic pulse_o
);

    logic prev_q;

    // History bit: value of the input on the previous cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= din_i;
        end
    end

    assign pulse_o = din_i & ~prev_q;

endmodule

// File: rtl/seleccionar_cartas_n.sv
// -----------------------------------------------------------------------------
// seleccionar_cartas_n
// Round selector for an N-card memory-game board laid out as a grid of COLS
// columns. A cursor moves with wrap-around; each round the player marks up to
// PICKS hidden cards as selected. The round ends when PICKS cards are picked or
// when no hidden card is left on the board.
//
// Optional build macro: SELECTOR_TIMEOUT_EN
//   When defined, a round with no move/select activity for TIMEOUT_CYC cycles
//   is aborted (done and timeout pulse together). When undefined, timeout is 0.
//
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   start               - level; loads arr_in and (re)starts a round
//   izq/der/arr/abj     - move left/right/up/down (edge-detected)
//   sel                 - select card under cursor (edge-detected)
//   arr_in              - board snapshot, card [1:0]=state, [CARD_W-1:2]=symbol
//   arr_out             - board with this round's selections applied
//   cursor              - current cursor index
//   pick_idx            - indices picked this round, slot 0 = first pick
//   pick_cnt            - number of picks so far
//   busy                - high while a round runs
//   done                - one-cycle pulse at round end
//   timeout             - one-cycle pulse with done when the round timed out
// -----------------------------------------------------------------------------
module seleccionar_cartas_n
    import cartas_pkg::*;
#(
    parameter  int N_CARDS     = 16,
    parameter  int COLS        = 4,
    parameter  int CARD_W      = 5,
    parameter  int PICKS       = 2,
    parameter  int TIMEOUT_CYC = 50_000_000,
    localparam int IDX_W       = $clog2(N_CARDS),
    localparam int CNT_W       = $clog2(PICKS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             izq,
    input  logic                             der,
    input  logic                             arr,
    input  logic                             abj,
    input  logic                             sel,
    input  logic [N_CARDS-1:0][CARD_W-1:0]   arr_in,
    output logic [N_CARDS-1:0][CARD_W-1:0]   arr_out,
    output logic [IDX_W-1:0]                 cursor,
    output logic [PICKS-1:0][IDX_W-1:0]      pick_idx,
    output logic [CNT_W-1:0]                 pick_cnt,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout
);

    // One extra bit so cursor+COLS and the board size itself never overflow.
    localparam logic [IDX_W:0]   N_W    = (IDX_W + 1)'(N_CARDS);
    localparam logic [IDX_W:0]   COLS_W = (IDX_W + 1)'(COLS);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_CARDS - 1);

    sel_state_t                      state_q, state_d;
    logic [N_CARDS-1:0][CARD_W-1:0]  board_q, board_d;
    logic [IDX_W-1:0]                cursor_q, cursor_d;
    logic [PICKS-1:0][IDX_W-1:0]     pickIdx_q, pickIdx_d;
    logic [CNT_W-1:0]                pickCnt_q, pickCnt_d;

    logic [IDX_W:0] stepSum;
    logic           hiddenLeft;
    logic           timerExpired;

    logic izqP, derP, arrP, abjP, selP;

    flanco_subida u_izq (.clk(clk), .rst(rst), .din_i(izq), .pulse_o(izqP));
    flanco_subida u_der (.clk(clk), .rst(rst), .din_i(der), .pulse_o(derP));
    flanco_subida u_arr (.clk(clk), .rst(rst), .din_i(arr), .pulse_o(arrP));
    flanco_subida u_abj (.clk(clk), .rst(rst), .din_i(abj), .pulse_o(abjP));
    flanco_subida u_sel (.clk(clk), .rst(rst), .din_i(sel), .pulse_o(selP));

`ifdef SELECTOR_TIMEOUT_EN
    // Counter wide enough for TIMEOUT_CYC-1, at least one bit.
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timedOut_q, timedOut_d;
    logic             anyPulse;

    assign anyPulse     = izqP | derP | arrP | abjP | selP;
    assign timerExpired = (state_q == RUN) && !anyPulse &&
                          (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    // Idle counter: restarts on any player activity or round (re)start and
    // only advances while a round is running.
    always_comb begin
        timer_d    = '0;
        timedOut_d = 1'b0;
        if (state_q == RUN && !start) begin
            if (timerExpired) begin
                timedOut_d = 1'b1;
            end else if (!anyPulse) begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q    <= '0;
            timedOut_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            timedOut_q <= timedOut_d;
        end
    end

    assign timeout = timedOut_q;
`else
    assign timerExpired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Round FSM, board, cursor and pick bookkeeping. start wins over
    // everything and reloads the round from any state. Within a round the
    // selection uses the cursor as it was before this cycle's move, and the
    // end-of-round test looks at the board after this cycle's pick so the
    // last pick and the transition share the same edge.
    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        cursor_d   = cursor_q;
        pickIdx_d  = pickIdx_q;
        pickCnt_d  = pickCnt_q;
        stepSum    = '0;
        hiddenLeft = 1'b0;

        if (start) begin
            state_d   = RUN;
            board_d   = arr_in;
            cursor_d  = '0;
            pickIdx_d = '0;
            pickCnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (selP && is_hidden(board_q[cursor_q][1:0]) &&
                        (pickCnt_q < CNT_W'(PICKS))) begin
                        board_d[cursor_q][1:0] = ST_SEL;
                        for (int i = 0; i < PICKS; i++) begin
                            if (pickCnt_q == CNT_W'(i)) begin
                                pickIdx_d[i] = cursor_q;
                            end
                        end
                        pickCnt_d = pickCnt_q + CNT_W'(1);
                    end

                    if (izqP) begin
                        cursor_d = (cursor_q == '0) ? LAST : cursor_q - IDX_W'(1);
                    end else if (derP) begin
                        cursor_d = (cursor_q == LAST) ? '0 : cursor_q + IDX_W'(1);
                    end else if (arrP) begin
                        if ({1'b0, cursor_q} >= COLS_W) begin
                            stepSum = {1'b0, cursor_q} - COLS_W;
                        end else begin
                            stepSum = {1'b0, cursor_q} + N_W - COLS_W;
                        end
                        cursor_d = stepSum[IDX_W-1:0];
                    end else if (abjP) begin
                        stepSum = {1'b0, cursor_q} + COLS_W;
                        if (stepSum >= N_W) begin
                            stepSum = stepSum - N_W;
                        end
                        cursor_d = stepSum[IDX_W-1:0];
                    end

                    for (int i = 0; i < N_CARDS; i++) begin
                        if (is_hidden(board_d[i][1:0])) begin
                            hiddenLeft = 1'b1;
                        end
                    end

                    if ((pickCnt_d == CNT_W'(PICKS)) || !hiddenLeft || timerExpired) begin
                        state_d = FIN;
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            board_q   <= '0;
            cursor_q  <= '0;
            pickIdx_q <= '0;
            pickCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            cursor_q  <= cursor_d;
            pickIdx_q <= pickIdx_d;
            pickCnt_q <= pickCnt_d;
        end
    end

    assign arr_out  = board_q;
    assign cursor   = cursor_q;
    assign pick_idx = pickIdx_q;
    assign pick_cnt = pickCnt_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == FIN);

endmodule
